// File: rtl/vector_sweep_sequencer_if.sv
// Handshake/bus bundle between the vector sweep sequencer (master) and its
// environment: control, circuit-under-test drive/response, record stream, signature.
interface vector_sweep_sequencer_if #(
    parameter int N_IN  = 4,
    parameter int OUT_W = 1
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [N_IN-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             rec_valid;
    logic             rec_ready;
    logic [N_IN-1:0]  rec_vec;
    logic [OUT_W-1:0] rec_resp;
    logic [15:0]      sig;

    modport master (
        input  start, abort, dut_out, rec_ready,
        output busy, done, dut_in, rec_valid, rec_vec, rec_resp, sig
    );

    modport slave (
        output start, abort, dut_out, rec_ready,
        input  busy, done, dut_in, rec_valid, rec_vec, rec_resp, sig
    );
endinterface

// File: rtl/vector_sweep_sequencer.sv
// Exhaustive vector sweep: drive each input vector, settle, sample, emit (vector, response).
// Optional CRC-16-CCITT response signature compiled in with SWEEP_SIG_EN.
module vector_sweep_sequencer #(
    parameter int N_IN   = 4,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1
) (
    input  logic                     CK,
    input  logic                     reset,
    vector_sweep_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EMIT} state_t;

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [N_IN-1:0]  r_dut_in;
    logic             r_rec_valid;
    logic [N_IN-1:0]  r_rec_vec;
    logic [OUT_W-1:0] r_rec_resp;

    logic w_start, w_abort, w_capture, w_accept, w_last;

    // abort outranks everything else once a sweep is running
    assign w_start   = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_abort   = (r_state != S_IDLE) && bus.abort;
    assign w_capture = (r_state == S_SETTLE) && !bus.abort && (r_cnt == CNT_LAST);
    assign w_accept  = (r_state == S_EMIT) && !bus.abort && r_rec_valid && bus.rec_ready;
    assign w_last    = &r_dut_in;

    always_ff @(posedge CK) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dut_in    <= '0;
            r_rec_valid <= 1'b0;
            r_rec_vec   <= '0;
            r_rec_resp  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_rec_valid <= 1'b0;
                r_dut_in    <= '0;
                r_cnt       <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_state  <= S_SETTLE;
                            r_dut_in <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (w_capture) begin
                            r_rec_resp  <= bus.dut_out;
                            r_rec_vec   <= r_dut_in;
                            r_rec_valid <= 1'b1;
                            r_state     <= S_EMIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_EMIT: begin
                        // terminal detection on all-ones keeps the vector counter from wrapping
                        if (w_accept) begin
                            r_rec_valid <= 1'b0;
                            if (w_last) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_dut_in <= r_dut_in + 1'b1;
                                r_cnt    <= '0;
                                r_state  <= S_SETTLE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef SWEEP_SIG_EN
    logic [15:0] r_sig;

    always_ff @(posedge CK) begin
        if (reset || w_start) begin
            r_sig <= 16'hFFFF;
        end else if (w_capture) begin
            r_sig <= {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000) ^ 16'(bus.dut_out);
        end
    end

    assign bus.sig = r_sig;
`else
    assign bus.sig = 16'h0000;
`endif

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dut_in    = r_dut_in;
    assign bus.rec_valid = r_rec_valid;
    assign bus.rec_vec   = r_rec_vec;
    assign bus.rec_resp  = r_rec_resp;
endmodule

// File: tb/tb_vector_sweep_sequencer.sv
// Directed bench for vector_sweep_sequencer: scoreboarded record streams for a
// SETTLE=1 instance (parity circuit) and a SETTLE=3 instance (2-stage echo circuit).
module tb_vector_sweep_sequencer;
    localparam int N_IN  = 4;
    localparam int OUT_W = 1;

`ifdef SWEEP_SIG_EN
    localparam logic [15:0] SIG_RST = 16'hFFFF;
`else
    localparam logic [15:0] SIG_RST = 16'h0000;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vector_sweep_sequencer_if #(.N_IN(N_IN), .OUT_W(OUT_W)) bus_a ();
    vector_sweep_sequencer_if #(.N_IN(N_IN), .OUT_W(OUT_W)) bus_b ();

    vector_sweep_sequencer #(.N_IN(N_IN), .OUT_W(OUT_W), .SETTLE(1)) u_dut_a (
        .CK(clk), .reset(reset), .bus(bus_a.master)
    );
    vector_sweep_sequencer #(.N_IN(N_IN), .OUT_W(OUT_W), .SETTLE(3)) u_dut_b (
        .CK(clk), .reset(reset), .bus(bus_b.master)
    );

    // circuits under test: combinational parity, and a 2-cycle registered echo of bit 0
    assign bus_a.dut_out = ^bus_a.dut_in;
    logic p1, p2;
    always @(posedge clk) begin
        p1 <= bus_b.dut_in[0];
        p2 <= p1;
    end
    assign bus_b.dut_out = p2;

    typedef struct packed {
        logic [3:0] vec;
        logic       resp;
    } rec_t;

    rec_t sb_a[$];
    rec_t sb_b[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_a = 0;
    int done_b = 0;
    int e0     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    // record monitors: a handshake is sampled mid-cycle, after the drivers have settled
    always @(negedge clk) begin
        #2;
        if (bus_a.done === 1'b1) done_a++;
        if (reset === 1'b0 && bus_a.rec_valid === 1'b1 && bus_a.rec_ready === 1'b1 && bus_a.abort === 1'b0) begin
            chk("a_sb_nonempty", 32'(sb_a.size() != 0), 32'd1);
            if (sb_a.size() != 0) begin
                rec_t e;
                e = sb_a.pop_front();
                chk("a_rec_vec", 32'(bus_a.rec_vec), 32'(e.vec));
                chk("a_rec_resp", 32'(bus_a.rec_resp), 32'(e.resp));
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (bus_b.done === 1'b1) done_b++;
        if (reset === 1'b0 && bus_b.rec_valid === 1'b1 && bus_b.rec_ready === 1'b1 && bus_b.abort === 1'b0) begin
            chk("b_sb_nonempty", 32'(sb_b.size() != 0), 32'd1);
            if (sb_b.size() != 0) begin
                rec_t e;
                e = sb_b.pop_front();
                chk("b_rec_vec", 32'(bus_b.rec_vec), 32'(e.vec));
                chk("b_rec_resp", 32'(bus_b.rec_resp), 32'(e.resp));
            end
        end
    end

    task automatic push_a();
        for (int v = 0; v < 16; v++) begin
            rec_t r;
            r.vec  = 4'(v);
            r.resp = ^r.vec;
            sb_a.push_back(r);
        end
    endtask

    task automatic start_a();
        bus_a.start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        bus_a.start = 1'b0;
        chk("a_busy_after_start", 32'(bus_a.busy), 32'd1);
        chk("a_dut_in_after_start", 32'(bus_a.dut_in), 32'd0);
    endtask

    task automatic wait_done_a(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) begin
                lat = cyc - e0;
                break;
            end
        end
    endtask

    task automatic wait_dut_in_a(input logic [3:0] v, input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus_a.dut_in === v) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int lat;
        int d0;
        int found;
        logic [15:0] exp_sig;

        reset           = 1'b1;
        bus_a.start     = 1'b1;
        bus_a.abort     = 1'b0;
        bus_a.rec_ready = 1'b1;
        bus_b.start     = 1'b0;
        bus_b.abort     = 1'b0;
        bus_b.rec_ready = 1'b1;

        // reset held two cycles with start high
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus_a.busy), 32'd0);
        chk("rst_done", 32'(bus_a.done), 32'd0);
        chk("rst_rec_valid", 32'(bus_a.rec_valid), 32'd0);
        chk("rst_dut_in", 32'(bus_a.dut_in), 32'd0);
        chk("rst_sig", 32'(bus_a.sig), 32'(SIG_RST));
        reset       = 1'b0;
        bus_a.start = 1'b0;
        @(negedge clk);
        chk("rst_no_sweep", 32'(bus_a.busy), 32'd0);

        // full sweep, ready held high
        push_a();
        d0 = done_a;
        start_a();
        wait_done_a(100, lat);
        chk("full_done_latency", 32'(lat), 32'd32);
        @(negedge clk);
        chk("full_done_one_cycle", 32'(bus_a.done), 32'd0);
        chk("full_busy_clear", 32'(bus_a.busy), 32'd0);
        @(negedge clk);
        chk("full_done_count", 32'(done_a - d0), 32'd1);
        chk("full_sb_drained", 32'(sb_a.size()), 32'd0);
`ifdef SWEEP_SIG_EN
        exp_sig = 16'hFFFF;
        for (int v = 0; v < 16; v++) begin
            logic [3:0] vv;
            vv = 4'(v);
            exp_sig = crc_step(exp_sig, {15'd0, ^vv});
        end
`else
        exp_sig = 16'h0000;
`endif
        chk("full_sig", 32'(bus_a.sig), 32'(exp_sig));

        // backpressure: stall vector 3 for five cycles
        push_a();
        start_a();
        found = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus_a.rec_valid === 1'b1 && bus_a.rec_vec === 4'd3) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("bp_reach_vec3", 32'(found), 32'd1);
        bus_a.rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", 32'(bus_a.rec_valid), 32'd1);
            chk("bp_vec_held", 32'(bus_a.rec_vec), 32'd3);
            chk("bp_dut_in_held", 32'(bus_a.dut_in), 32'd3);
        end
        bus_a.rec_ready = 1'b1;
        wait_done_a(100, lat);
        chk("bp_done_latency", 32'(lat), 32'd37);
        @(negedge clk);
        chk("bp_sb_drained", 32'(sb_a.size()), 32'd0);

        // SETTLE=3 instance with the registered echo circuit
        for (int v = 0; v < 16; v++) begin
            rec_t r;
            r.vec  = 4'(v);
            r.resp = r.vec[0];
            sb_b.push_back(r);
        end
        d0 = done_b;
        bus_b.start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        bus_b.start = 1'b0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_b.done === 1'b1) begin
                lat = cyc - e0;
                break;
            end
        end
        chk("s3_done_latency", 32'(lat), 32'd64);
        @(negedge clk);
        @(negedge clk);
        chk("s3_done_count", 32'(done_b - d0), 32'd1);
        chk("s3_sb_drained", 32'(sb_b.size()), 32'd0);

        // abort while vector 7 is applied
        push_a();
        start_a();
        wait_dut_in_a(4'd7, "ab_reach_vec7");
        d0 = done_a;
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        chk("ab_busy", 32'(bus_a.busy), 32'd0);
        chk("ab_rec_valid", 32'(bus_a.rec_valid), 32'd0);
        chk("ab_dut_in", 32'(bus_a.dut_in), 32'd0);
        chk("ab_done", 32'(bus_a.done), 32'd0);
        chk("ab_records_left", 32'(sb_a.size()), 32'd9);
        sb_a.delete();
        repeat (3) @(negedge clk);
        chk("ab_no_done", 32'(done_a - d0), 32'd0);

        // restart after abort, with a stray start while busy
        push_a();
        start_a();
        wait_dut_in_a(4'd5, "rs_reach_vec5");
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        chk("rs_busy_kept", 32'(bus_a.busy), 32'd1);
        wait_done_a(100, lat);
        chk("rs_done_latency", 32'(lat), 32'd32);
        @(negedge clk);
        chk("rs_sb_drained", 32'(sb_a.size()), 32'd0);

        // reset in the middle of a sweep
        push_a();
        start_a();
        wait_dut_in_a(4'd9, "mr_reach_vec9");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_busy", 32'(bus_a.busy), 32'd0);
        chk("mr_rec_valid", 32'(bus_a.rec_valid), 32'd0);
        chk("mr_dut_in", 32'(bus_a.dut_in), 32'd0);
        chk("mr_rec_vec", 32'(bus_a.rec_vec), 32'd0);
        chk("mr_rec_resp", 32'(bus_a.rec_resp), 32'd0);
        chk("mr_sig", 32'(bus_a.sig), 32'(SIG_RST));
        sb_a.delete();
        repeat (2) @(negedge clk);
        chk("mr_stays_idle", 32'(bus_a.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/vector_sweep_sequencer.md
# vector_sweep_sequencer

Controller that sequences exhaustive stimulus into a small combinational or sequential benchmark circuit under test (up to 2^N_IN input vectors), waits a programmable settle time per vector, samples the circuit response, and streams each (vector, response) record out over a valid/ready handshake. It replaces free-running testbench sweeps with a synthesizable, backpressure-aware sequencer. The record stream feeds the response logger or comparator used in the trojan-detection flow.

## Interface
- N_IN, default 4: width of the driven input vector; the sweep covers 0 .. 2^N_IN-1.
- OUT_W, default 1: width of the sampled response; must be 1..16.
- SETTLE, default 1: cycles between applying a vector and sampling the response; must be >= 1.

- CK  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a sweep when sampled high while idle.
- abort  in  1  cancels a sweep in progress.
- busy  out  1  high from the start edge until the final handshake or abort.
- done  out  1  one-cycle pulse after the last record is accepted.
- dut_in  out  N_IN  vector driven into the circuit under test.
- dut_out  in  OUT_W  response of the circuit under test.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts the record.
- rec_vec  out  N_IN  vector the record belongs to.
- rec_resp  out  OUT_W  captured response.
- sig  out  16  response signature; see Configuration.

## Operation
- States: IDLE, SETTLE, EMIT.
- IDLE: on start=1 and abort=0, set dut_in=0, cnt=0, busy=1, and move to SETTLE. The signature loads 16'hFFFF.
- SETTLE: cnt increments each cycle. On the edge where cnt==SETTLE-1:
  - capture dut_out into rec_resp;
  - set rec_vec=dut_in and rec_valid=1;
  - update the signature;
  - move to EMIT.
- EMIT: hold rec_valid, rec_vec, rec_resp and dut_in stable until rec_valid&&rec_ready.
  - On that handshake, if dut_in is all ones: rec_valid=0, busy=0, done=1 for one cycle, move to IDLE.
  - Otherwise: dut_in+1, cnt=0, rec_valid=0, move to SETTLE.
- The vector counter never wraps. Terminal detection is the all-ones vector, so exactly 2^N_IN records are produced per sweep.
- start is ignored while busy.
- abort, when not in IDLE, wins over a handshake in the same cycle. At the next edge: IDLE, busy=0, rec_valid=0, dut_in=0, no done pulse. The signature keeps its value. abort in IDLE is a no-op and suppresses a simultaneous start.
- Reset, including mid-sweep, sets:
  - busy=0, done=0, rec_valid=0;
  - dut_in=0, rec_vec=0, rec_resp=0;
  - cnt=0, state IDLE;
  - sig=16'hFFFF with the signature compiled in, 16'h0000 without.

## Timing
- Let E0 be the edge that accepts start. dut_in=0 is valid after E0.
- The response is sampled at edge E0+SETTLE; rec_valid is high after that edge.
- With rec_ready held high, each vector takes SETTLE+1 cycles.
- done pulses after edge E0 + 2^N_IN*(SETTLE+1). For defaults, this is 32 cycles after E0.
- Each cycle rec_ready is low during EMIT adds one cycle. No vector is skipped or repeated.
- A new start is accepted the cycle after done, since state is IDLE.

## Configuration
- SWEEP_SIG_EN defined: sig is a CRC-16-CCITT accumulator.
  - At every capture: sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended rec_resp input value.
  - sig is loaded with 16'hFFFF at start and at reset.
- SWEEP_SIG_EN undefined: no accumulator logic; sig is constant 16'h0000.

## Test plan
- Reset: hold reset 2 cycles with start=1 → busy=0, done=0, rec_valid=0, dut_in=0, and sig=16'hFFFF (16'h0000 without the macro); no sweep starts.
- Full sweep, defaults, rec_ready=1, bench model dut_out=^dut_in → 16 records, rec_vec 0..15 in order, rec_resp = parity of rec_vec; exactly one done pulse, 32 cycles after E0.
- Backpressure: drop rec_ready for 5 cycles while rec_vec=3 → rec_valid stays high, rec_vec=3, dut_in=3 stable; the next record is 4; done is delayed by exactly 5 cycles (37 after E0).
- SETTLE=3 with a 2-cycle registered bench DUT echoing dut_in[0] → all 16 responses correct; done 64 cycles after E0.
- abort while dut_in=7 → next cycle busy=0, rec_valid=0, dut_in=0, no done. Restart: first record rec_vec=0. start pulsed while busy has no effect.
- SWEEP_SIG_EN defined: first captured rec_resp=1 after start → sig=16'hDEDE. A mid-sweep reset returns sig to 16'hFFFF.
